// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges pipeline results and FIFO-buffered mult/div results onto the
// register-file write port, and tracks outstanding mult/div destinations. Optional: WB_MD_BYPASS_EN.
module wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic          clock,
    input  logic          ctrl_reset,
    input  logic          pipe_we,
    input  logic [4:0]    pipe_rd,
    input  logic [31:0]   pipe_data,
    input  logic          md_issue,
    input  logic [4:0]    md_issue_rd,
    input  logic          md_valid,
    input  logic [4:0]    md_rd,
    input  logic [31:0]   md_data,
    output logic          md_ready,
    output logic          ctrl_writeEnable,
    output logic [4:0]    ctrl_writeReg,
    output logic [31:0]   data_writeReg,
    output logic [31:0]   busy_mask,
    output logic [AW:0]   fifo_count
);

    logic [4:0]    rd_mem_q   [DEPTH];
    logic [4:0]    rd_mem_d   [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];
    logic [31:0]   data_mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          we_q, we_d;
    logic [4:0]    reg_q, reg_d;
    logic [31:0]   data_q, data_d;
    logic [31:0]   busy_q, busy_d;

    logic          full, empty, pipe_sel, bypass, push, pop, clr_en;
    logic [4:0]    clr_rd;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        pipe_sel = pipe_we && (pipe_rd != '0);
`ifdef WB_MD_BYPASS_EN
        bypass   = !pipe_sel && empty && md_valid;
`else
        bypass   = 1'b0;
`endif
        // A bypassed result never occupies a slot.
        push     = md_valid && !full && !bypass;
        pop      = !pipe_sel && !empty;

        we_d   = 1'b0;
        reg_d  = reg_q;
        data_d = data_q;
        clr_en = 1'b0;
        clr_rd = '0;
        if (pipe_sel) begin
            we_d   = 1'b1;
            reg_d  = pipe_rd;
            data_d = pipe_data;
        end else if (pop) begin
            we_d   = (rd_mem_q[rd_ptr_q] != '0);
            reg_d  = rd_mem_q[rd_ptr_q];
            data_d = data_mem_q[rd_ptr_q];
            clr_en = 1'b1;
            clr_rd = rd_mem_q[rd_ptr_q];
        end else if (bypass) begin
            we_d   = (md_rd != '0);
            reg_d  = md_rd;
            data_d = md_data;
            clr_en = 1'b1;
            clr_rd = md_rd;
        end

        // Issue is applied after clear so a same-cycle set wins.
        busy_d = busy_q;
        if (clr_en)
            busy_d[clr_rd] = 1'b0;
        if (md_issue && (md_issue_rd != '0))
            busy_d[md_issue_rd] = 1'b1;
        busy_d[0] = 1'b0;

        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) begin
            rd_mem_d[wr_ptr_q]   = md_rd;
            data_mem_d[wr_ptr_q] = md_data;
            wr_ptr_d             = wr_ptr_q + AW'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            reg_q    <= '0;
            data_q   <= '0;
            busy_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            we_q     <= we_d;
            reg_q    <= reg_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
        end
    end

    // Storage needs no reset: occupancy is governed by the pointers and count.
    always_ff @(posedge clock) begin
        rd_mem_q   <= rd_mem_d;
        data_mem_q <= data_mem_d;
    end

    assign md_ready         = !full;
    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = reg_q;
    assign data_writeReg    = data_q;
    assign busy_mask        = busy_q;
    assign fifo_count       = count_q;

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the register file's single write port.
- Merges two result sources onto that port:
  - single-cycle pipeline results (ALU/load), and
  - long-latency multiply/divide results, which are buffered in a small FIFO.
- Keeps a per-register scoreboard of outstanding mult/div destinations so decode can stall on RAW/WAW hazards.

Parameters:
- DEPTH, 2, number of entries in the mult/div result FIFO (power of two, >=2).
- AW, 1, FIFO pointer width, log2(DEPTH).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- ctrl_reset  in  1  reset, asynchronous, active-high.
- pipe_we  in  1  pipeline W-stage write request; always accepted, never back-pressured.
- pipe_rd  in  5  pipeline destination register.
- pipe_data  in  32  pipeline result.
- md_issue  in  1  a mult/div op is dispatched this cycle.
- md_issue_rd  in  5  destination of the dispatched op.
- md_valid  in  1  mult/div result offered.
- md_rd  in  5  destination of the offered result.
- md_data  in  32  offered result.
- md_ready  out  1  FIFO can accept; equals !full, combinational.
- ctrl_writeEnable  out  1  registered write enable to the register file.
- ctrl_writeReg  out  5  registered write address.
- data_writeReg  out  32  registered write data.
- busy_mask  out  32  bit i set = register i has an outstanding mult/div result.
- fifo_count  out  AW+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0.
  - busy_mask=0, FIFO emptied (fifo_count=0), pointers to 0.
  - All in-flight entries are discarded; md_ready=1 during and after reset.
- Push: md_valid && md_ready at posedge writes {md_rd, md_data} at the write pointer. The write pointer wraps modulo DEPTH.
- Source select each cycle, fixed priority:
  - pipe_we && pipe_rd!=0: pipeline wins. At the next posedge the outputs load {1, pipe_rd, pipe_data}.
  - Else, FIFO non-empty: pop the head. Outputs load {1, head_rd, head_data}; the read pointer advances and wraps.
  - Else: ctrl_writeEnable loads 0; ctrl_writeReg and data_writeReg hold their values.
- Latency:
  - Pipeline result: one cycle to the outputs; the register file commits it on the following edge.
  - FIFO entry: at least one cycle after push when the path is unblocked.
- Register 0:
  - A pipe write with pipe_rd=0 is ignored; it does not block a FIFO pop.
  - A FIFO entry with rd=0 is popped but drives ctrl_writeEnable=0.
- Simultaneous push and pop: allowed at any occupancy below full; count is unchanged. When full, md_ready=0, so no push occurs that cycle even if a pop frees a slot (no same-cycle pass-through when full).
- Starvation: continuous pipe_we starves the FIFO. Mult/div sources hold md_valid until md_ready; no data is lost.
- Scoreboard:
  - md_issue with md_issue_rd!=0 sets busy_mask[md_issue_rd] at posedge.
  - A bit clears at the posedge where a popped entry with the same rd loads the outputs.
  - Set and clear of the same bit in one cycle: set wins.
  - busy_mask[0] is always 0.
  - Pipeline writes never modify busy_mask.

Optional Feature:
- Macro: WB_MD_BYPASS_EN.
- Defined: when the FIFO is empty, no valid pipe write is present, and md_valid=1:
  - the result skips storage and loads the outputs directly at that posedge;
  - fifo_count stays 0;
  - the scoreboard clears as for a pop.
- Undefined: every mult/div result passes through the FIFO, giving a minimum of 2 cycles from md_valid to ctrl_writeEnable.

Test Plan:
- Reset, then pipe_we=1, rd=5, data=32'h1234 for one cycle -> next cycle we=1, reg=5, data=32'h1234; following cycle we=0.
- md_issue rd=7 -> busy_mask=32'h80. Then md_valid rd=7, data=32'hDEAD with no pipe traffic -> we=1, reg=7, data=32'hDEAD two cycles after md_valid (one with bypass), and busy_mask returns to 0 on the same edge.
- Hold pipe_we=1 for 4 cycles while pushing md results for rd 3 and 4 -> fifo_count=2, md_ready=0, third md_valid held. After pipe_we drops -> rd3 then rd4 written in order, md_ready returns to 1.
- md_issue rd=9 in the same cycle an entry for rd=9 pops -> busy_mask[9] remains 1.
- pipe_rd=0 with pipe_we=1 and FIFO holding rd=2 -> rd=2 written next cycle. A FIFO entry with rd=0 -> popped with we=0.
- Assert ctrl_reset mid-cycle with fifo_count=2 and busy_mask nonzero -> immediately all outputs 0, fifo_count=0, md_ready=1; no stale write after reset release.
